// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC instruction fetch feeding a DEPTH-entry prefetch
// queue, with a one-cycle-latency instruction memory and a decode-side
// valid/ready handshake. A redirect flushes the queue and any in-flight
// response, then restarts fetch at the target.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect raises a
// sticky fetch_fault that stalls fetch until an aligned redirect arrives).
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redir_valid,
  input  logic [XLEN-1:0]            redir_pc,
  output logic                       instr_valid,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            infl_q, infl_d;
  logic [XLEN-1:0] infl_addr_q, infl_addr_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] addr_d [DEPTH];
  logic [XLEN-1:0] last_instr_q, last_instr_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  logic [CW:0]     occ;
  logic            issue;
  logic            push;
  logic            pop;

  // Issue decision: the credit counts queued entries plus the outstanding
  // request; a same-cycle pop is not credited, so a full queue resumes
  // fetching one cycle after its first pop. Gated by rst so no request is
  // seen while reset is held.
  always_comb begin
    occ   = {1'b0, count_q} + (CW+1)'(infl_q);
    issue = rst && !redir_valid && !fault_q && (occ < (CW+1)'(DEPTH));
    push  = infl_q;
    pop   = (count_q != '0) && instr_ready;
  end

  // Head presentation; when empty, the last shown instruction/PC is held.
  always_comb begin
    instr_valid = (count_q != '0);
    instr       = instr_valid ? data_q[rd_q] : last_instr_q;
    instr_pc    = instr_valid ? addr_q[rd_q] : last_pc_q;
    imem_req    = issue;
    imem_addr   = pc_q;
    q_count     = count_q;
    fetch_fault = fault_q;
  end

  // Next-state: redirect overrides push, pop and issue in the same cycle.
  always_comb begin
    pc_d         = pc_q;
    infl_d       = 1'b0;
    infl_addr_d  = infl_addr_q;
    fault_d      = fault_q;
    count_d      = count_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    data_d       = data_q;
    addr_d       = addr_q;
    last_instr_d = instr;
    last_pc_d    = instr_pc;
    if (redir_valid) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_d = (redir_pc[1:0] != 2'b00);
      pc_d    = redir_pc;
`else
      fault_d = 1'b0;
      pc_d    = {redir_pc[XLEN-1:2], 2'b00};
`endif
    end else begin
      if (push) begin
        data_d[wr_q] = imem_rdata;
        addr_d[wr_q] = infl_addr_q;
        wr_d         = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        infl_d      = 1'b1;
        infl_addr_d = pc_q;
        pc_d        = pc_q + XLEN'(PC_STEP);
      end
    end
  end

  // State registers; reset discards queue contents and any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      infl_q       <= 1'b0;
      infl_addr_q  <= '0;
      fault_q      <= 1'b0;
      count_q      <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      data_q       <= '{default: '0};
      addr_q       <= '{default: '0};
      last_instr_q <= '0;
      last_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      infl_q       <= infl_d;
      infl_addr_q  <= infl_addr_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations, then
// randomized ready/redirect traffic compared every cycle against a queue model.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int STEP  = 4;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  q_count;
  logic        fetch_fault;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .q_count(q_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: answers the request seen in the previous cycle; junk otherwise.
  logic        mreq = 1'b0;
  logic [31:0] maddr = '0;
  always @(negedge clk) begin
    mreq  = imem_req;
    maddr = imem_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rdata = mreq ? (maddr ^ KEY) : $urandom;
  end

  // Reference model: queue of (pc, data), one outstanding request, fetch PC.
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_addr;
  logic        m_fault;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;
  logic        exp_req;

  task automatic model_reset();
    mq.delete();
    m_pc         = RPC;
    m_infl       = 1'b0;
    m_infl_addr  = '0;
    m_fault      = 1'b0;
    m_last_pc    = '0;
    m_last_instr = '0;
  endtask

  // Per-cycle comparison against the model, then model advance for the edge.
  always @(negedge clk) begin
    if (checking && rst) begin
      exp_req = !m_fault && !redir_valid && ((mq.size() + (m_infl ? 1 : 0)) < DEPTH);
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("q_count", q_count, mq.size());
      chk("q_count_bound", q_count <= DEPTH, 1);
      chk("instr_valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        m_last_pc    = mq[0].pc;
        m_last_instr = mq[0].data;
      end
      chk("instr_pc", instr_pc, m_last_pc);
      chk("instr", instr, m_last_instr);
      chk("fetch_fault", fetch_fault, m_fault);
      if (redir_valid) begin
        mq.delete();
        m_infl = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        m_fault = (redir_pc[1:0] != 2'b00);
        m_pc    = redir_pc;
`else
        m_fault = 1'b0;
        m_pc    = redir_pc & ~32'h3;
`endif
      end else begin
        if (m_infl && mq.size() >= DEPTH)
          chk("push_into_full_queue", mq.size(), DEPTH - 1);
        if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
        if (m_infl) mq.push_back('{pc: m_infl_addr, data: m_infl_addr ^ KEY});
        m_infl = exp_req;
        if (exp_req) begin
          m_infl_addr = m_pc;
          m_pc        = m_pc + STEP;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_imem_addr"}, imem_addr, RPC);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_q_count"}, q_count, 0);
    chk({tag, "_fetch_fault"}, fetch_fault, 0);
  endtask

  task automatic do_reset();
    checking    = 1'b0;
    redir_valid = 1'b0;
    rst         = 1'b0;
    #1;
    check_reset_vals("rst");
    cyc();
    cyc();
  endtask

  task automatic release_reset();
    cyc();
    model_reset();
    rst      = 1'b1;
    checking = 1'b1;
  endtask

  task automatic wait_count(input int n);
    int i = 0;
    while (q_count != n && i < 20) begin
      cyc();
      i++;
    end
    chk("wait_q_count", q_count, n);
  endtask

  initial begin
    rst = 1'b0; redir_valid = 1'b0; redir_pc = '0; instr_ready = 1'b0;
    #2;
    check_reset_vals("por");

    // Streaming after reset with decode always ready.
    instr_ready = 1'b1;
    release_reset();
    #1;
    chk("t1_first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
    chk("t1_valid_c0", instr_valid, 0);
    cyc(); #1;
    chk("t1_valid_c1", instr_valid, 0);
    cyc(); #1;
    chk("t1_head_c2", {instr_valid, instr_pc, instr}, {1'b1, 32'h0, 32'hA5A5_0000});
    for (int k = 1; k < 8; k++) begin
      cyc(); #1;
      chk("t1_stream", {instr_valid, instr_pc}, {1'b1, 32'(4 * k)});
    end

    // Back-pressure: fill, stall, then drain in order.
    do_reset();
    instr_ready = 1'b0;
    release_reset();
    repeat (10) cyc();
    chk("t2_full", q_count, 4);
    chk("t2_req_stalled", imem_req, 0);
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      #1;
      chk("t2_drain", {instr_valid, instr_pc}, {1'b1, 32'(4 * k)});
      if (k == 0) chk("t2_req_pop_cycle", imem_req, 0);
      if (k == 1) chk("t2_req_resume", imem_req, 1);
    end

    // Redirect with three queued entries and one in flight.
    do_reset();
    instr_ready = 1'b0;
    release_reset();
    wait_count(3);
    redir_valid = 1'b1; redir_pc = 32'h100;
    #1;
    chk("t3_req_during_redir", imem_req, 0);
    cyc();
    redir_valid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("t3_flushed", q_count, 0);
    chk("t3_req_target", {imem_req, imem_addr}, {1'b1, 32'h100});
    cyc(); cyc(); #1;
    chk("t3_head", {instr_valid, instr_pc, instr}, {1'b1, 32'h100, 32'hA5A5_0100});

    // Back-to-back redirects: only the last target stream survives.
    repeat (3) cyc();
    redir_valid = 1'b1; redir_pc = 32'h200;
    cyc();
    redir_pc = 32'h300;
    #1;
    chk("t4_req_second_redir", imem_req, 0);
    cyc();
    redir_valid = 1'b0;
    #1;
    chk("t4_req_target", {imem_req, imem_addr}, {1'b1, 32'h300});
    cyc(); #1;
    chk("t4_not_yet_valid", instr_valid, 0);
    cyc(); #1;
    chk("t4_head", {instr_valid, instr_pc}, {1'b1, 32'h300});

    // Misaligned redirect.
    cyc();
    redir_valid = 1'b1; redir_pc = 32'h102;
    cyc();
    redir_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t5_fault", {fetch_fault, imem_req, instr_valid}, {1'b1, 1'b0, 1'b0});
    repeat (3) cyc();
    chk("t5_fault_sticky", {fetch_fault, imem_req}, {1'b1, 1'b0});
    redir_valid = 1'b1; redir_pc = 32'h104;
    cyc();
    redir_valid = 1'b0;
    #1;
    chk("t5_fault_clear", {fetch_fault, imem_req, imem_addr}, {1'b0, 1'b1, 32'h104});
    cyc(); cyc(); #1;
    chk("t5_head", {instr_valid, instr_pc}, {1'b1, 32'h104});
`else
    chk("t5_masked_req", {fetch_fault, imem_req, imem_addr}, {1'b0, 1'b1, 32'h100});
    cyc(); cyc(); #1;
    chk("t5_masked_head", {instr_valid, instr_pc}, {1'b1, 32'h100});
`endif

    // Asynchronous reset in the middle of a cycle with two entries queued.
    do_reset();
    instr_ready = 1'b0;
    release_reset();
    wait_count(2);
    #2;
    checking = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_vals("mid");
    cyc(); cyc();
    release_reset();
    #1;
    chk("t6_restart", {imem_req, imem_addr}, {1'b1, RPC});

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cyc();
      instr_ready = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       redir_pc = 32'hFFFF_FFF4;
        1:       redir_pc = $urandom;
        default: redir_pc = 32'($urandom_range(0, 4095) << 2);
      endcase
    end
    cyc();
    redir_valid = 1'b0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
